// File: rtl/tl_pkg.sv
// Shared definitions for the intersection sequencer.
// Contents: phase enum (3-bit state codes), one-hot light encodings
// {red,yellow,green}, and the active-low seven-segment decoder {g..a}.
package tl_pkg;

  typedef enum logic [2:0] {
    PH_HG  = 3'd0,
    PH_HY  = 3'd1,
    PH_AR1 = 3'd2,
    PH_FG  = 3'd3,
    PH_FY  = 3'd4,
    PH_AR2 = 3'd5
  } phase_e;

  localparam int unsigned LT_W   = 3;
  localparam int unsigned SEG_W  = 7;
  localparam int unsigned TIME_W = 4;

  localparam logic [LT_W-1:0] LT_GREEN  = 3'b001;
  localparam logic [LT_W-1:0] LT_YELLOW = 3'b010;
  localparam logic [LT_W-1:0] LT_RED    = 3'b100;

  // Active-low segments {g,f,e,d,c,b,a}; values above 9 are blanked.
  function automatic logic [SEG_W-1:0] seg7(input logic [TIME_W-1:0] v);
    logic [SEG_W-1:0] s;
    case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/tl_tick_gen.sv
// One-second tick generator.
// Ports: clk, rst (sync, active-high), clr (restart count from 0),
//        tick (1-cycle pulse when the count reaches TICK_DIV-1).
module tl_tick_gen #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == CNT_MAX);

  // Divider wraps after the tick and restarts whenever the phase changes.
  always_ff @(posedge clk) begin
    if (rst || clr || tick) cnt <= '0;
    else                    cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/intersection_sequencer.sv
// Highway/farm intersection controller: one FSM sequences both approaches
// with all-red clearance, a farm-road sensor, a built-in 1 s tick and an
// active-low seven-segment countdown.
// Ports: clk, rst (sync, active-high), C (farm vehicle sensor),
//        light_highway/light_farm (one-hot {red,yellow,green}),
//        phase (state code), remaining (ticks left), outled (segments {g..a}).
// Build option: define TL_SENSOR_EN to let C extend highway green and
// gap out farm green; otherwise C is ignored and a fixed cycle runs.
module intersection_sequencer
  import tl_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned HGREEN_S = 5,
  parameter int unsigned YELLOW_S = 3,
  parameter int unsigned ALLRED_S = 1,
  parameter int unsigned FGREEN_S = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       C,
  output logic [2:0] light_highway,
  output logic [2:0] light_farm,
  output logic [2:0] phase,
  output logic [3:0] remaining,
  output logic [6:0] outled
);

  localparam logic [TIME_W-1:0] HG_D = TIME_W'(HGREEN_S);
  localparam logic [TIME_W-1:0] Y_D  = TIME_W'(YELLOW_S);
  localparam logic [TIME_W-1:0] AR_D = TIME_W'(ALLRED_S);
  localparam logic [TIME_W-1:0] FG_D = TIME_W'(FGREEN_S);

  phase_e              state, state_nxt;
  logic [TIME_W-1:0]   rem, rem_nxt;
  logic [LT_W-1:0]     lhw_nxt, lfm_nxt;
  logic                tick, expire, clr;

  assign clr       = (state_nxt != state);
  assign phase     = state;
  assign remaining = rem;

`ifndef TL_SENSOR_EN
  logic unused_c;
  assign unused_c = C;
`endif

  tl_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .tick (tick)
  );

  // Next-state and timer logic.
  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    expire    = tick && (rem == 4'd1);
    if (tick && (rem > 4'd1)) rem_nxt = rem - 4'd1;
    case (state)
      PH_HG: begin
`ifdef TL_SENSOR_EN
        // Green is extended (timer parked at 0) until a farm vehicle shows up.
        if ((rem == 4'd0 || expire) && C) begin
          state_nxt = PH_HY;
          rem_nxt   = Y_D;
        end else if (expire) begin
          rem_nxt   = 4'd0;
        end
`else
        if (expire) begin
          state_nxt = PH_HY;
          rem_nxt   = Y_D;
        end
`endif
      end
      PH_HY: if (expire) begin
        state_nxt = PH_AR1;
        rem_nxt   = AR_D;
      end
      PH_AR1: if (expire) begin
        state_nxt = PH_FG;
        rem_nxt   = FG_D;
      end
      PH_FG: begin
`ifdef TL_SENSOR_EN
        // Gap-out: farm green ends at the first tick with no vehicle.
        if (tick && (rem == 4'd1 || !C)) begin
`else
        if (expire) begin
`endif
          state_nxt = PH_FY;
          rem_nxt   = Y_D;
        end
      end
      PH_FY: if (expire) begin
        state_nxt = PH_AR2;
        rem_nxt   = AR_D;
      end
      PH_AR2: if (expire) begin
        state_nxt = PH_HG;
        rem_nxt   = HG_D;
      end
      default: begin
        state_nxt = PH_HG;
        rem_nxt   = HG_D;
      end
    endcase
  end

  // Light decode of the next state, so the light registers track the state.
  always_comb begin
    lhw_nxt = LT_RED;
    lfm_nxt = LT_RED;
    case (state_nxt)
      PH_HG:   lhw_nxt = LT_GREEN;
      PH_HY:   lhw_nxt = LT_YELLOW;
      PH_FG:   lfm_nxt = LT_GREEN;
      PH_FY:   lfm_nxt = LT_YELLOW;
      default: ;
    endcase
  end

  // State, timer and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= PH_HG;
      rem           <= HG_D;
      light_highway <= LT_GREEN;
      light_farm    <= LT_RED;
      outled        <= seg7(HG_D);
    end else begin
      state         <= state_nxt;
      rem           <= rem_nxt;
      light_highway <= lhw_nxt;
      light_farm    <= lfm_nxt;
      outled        <= seg7(rem_nxt);
    end
  end

endmodule
